// File: rtl/rtc_pkg.sv
// Shared definitions for the multi-channel RTC capture block: register selects,
// channel state encoding and fixed constants.
package rtc_pkg;

  localparam logic [7:0] REG_TIME   = 8'h00;
  localparam logic [7:0] REG_STATE  = 8'h01;
  localparam logic [7:0] REG_STAMP  = 8'h02;
  localparam logic [7:0] REG_ARM    = 8'h03;
  localparam logic [7:0] REG_WINDOW = 8'h04;
  localparam logic [7:0] REG_PEAK   = 8'h05;
  localparam logic [7:0] REG_BLEN   = 8'h06;
  localparam logic [7:0] REG_BURST  = 8'h07;
  localparam logic [7:0] REG_BTS    = 8'h08;

  localparam logic [31:0] DEADBEEF      = 32'hDEAD_BEEF;
  localparam int unsigned BURST_LEN_DEF = 5000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_QUALIFY  = 2'd2,
    ST_CAPTURED = 2'd3
  } ch_state_e;

endpackage

// File: rtl/rtc_capture_channel.sv
// One capture channel: input synchroniser, rising-edge detect, and the
// arm/qualify/capture state machine that only stamps sustained events.
module rtc_capture_channel
  import rtc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             event_i,
  input  logic             arm_wr_i,
  input  logic             arm_en_i,
  input  logic [CNT_W-1:0] time_cnt_i,
  input  logic [CNT_W-1:0] window_i,
  input  logic [CNT_W-1:0] peak_i,
  output ch_state_e        state_o,
  output logic [CNT_W-1:0] stamp_o,
  output logic             valid_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   rise_q;
  ch_state_e              state_q;
  logic [CNT_W-1:0]       cand_q, stamp_q, win_cnt_q, win_len_q, peak_q, hits_q;
  logic                   valid_q;
  logic [CNT_W-1:0]       hits_d;

  // rise_q and lvl_q stay aligned so the first qualifying sample is the edge itself
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_i};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
    end
  end

  assign hits_d = hits_q + CNT_W'(lvl_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      stamp_q   <= '0;
      win_cnt_q <= '0;
      win_len_q <= '0;
      peak_q    <= '0;
      hits_q    <= '0;
      valid_q   <= 1'b0;
    end else if (arm_wr_i) begin
      state_q <= arm_en_i ? ST_ARMED : ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (rise_q) begin
            cand_q    <= time_cnt_i;
            win_cnt_q <= '0;
            hits_q    <= '0;
            win_len_q <= (window_i == '0) ? CNT_W'(1) : window_i;
            peak_q    <= peak_i;
            state_q   <= ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          win_cnt_q <= win_cnt_q + CNT_W'(1);
          hits_q    <= hits_d;
          if (win_cnt_q == win_len_q - CNT_W'(1)) begin
            if (hits_d >= peak_q) begin
              stamp_q <= cand_q;
              valid_q <= 1'b1;
              state_q <= ST_CAPTURED;
            end else begin
              state_q <= ST_ARMED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;
  assign stamp_o = stamp_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/rtc_multi_capture.sv
// Multi-channel RTC capture top: timebase, Avalon-MM register slave and optional
// piezo burst generator (enabled by defining RTC_BURST_OUT_EN).
module rtc_multi_capture
  import rtc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int WINDOW_DEF  = 4000,
  parameter int PEAK_DEF    = 2500,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [15:0]       avalon_slave_address,
  input  logic              avalon_slave_write,
  input  logic [31:0]       avalon_slave_writedata,
  input  logic              avalon_slave_read,
  output logic [31:0]       avalon_slave_readdata,
  output logic              avalon_slave_waitrequest,
  output logic              irq,
  output logic              piezo_enable
);

  logic [7:0]       reg_sel, ch_idx;
  logic             ch_ok;
  logic [CNT_W-1:0] wdata_cnt;
  logic [CNT_W-1:0] time_cnt_q, window_q, peak_q;
  logic [31:0]      readdata_q, rd_mux;
  logic             rd_done_q;
  ch_state_e        ch_state [NUM_CH];
  logic [CNT_W-1:0] ch_stamp [NUM_CH];
  logic [NUM_CH-1:0] ch_valid;
  ch_state_e        sel_state;
  logic [CNT_W-1:0] sel_stamp;

  assign reg_sel   = avalon_slave_address[15:8];
  assign ch_idx    = avalon_slave_address[7:0];
  assign ch_ok     = (ch_idx < 8'(NUM_CH));
  assign wdata_cnt = avalon_slave_writedata[CNT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_cnt_q <= '0;
      window_q   <= CNT_W'(WINDOW_DEF);
      peak_q     <= CNT_W'(PEAK_DEF);
    end else begin
      if (avalon_slave_write && reg_sel == REG_TIME) time_cnt_q <= wdata_cnt;
      else                                           time_cnt_q <= time_cnt_q + CNT_W'(1);
      if (avalon_slave_write && reg_sel == REG_WINDOW) window_q <= wdata_cnt;
      if (avalon_slave_write && reg_sel == REG_PEAK)   peak_q   <= wdata_cnt;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      rtc_capture_channel #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clock      (clock),
        .reset      (reset),
        .event_i    (event_in[gi]),
        .arm_wr_i   (avalon_slave_write && reg_sel == REG_ARM && ch_idx == 8'(gi)),
        .arm_en_i   (|avalon_slave_writedata),
        .time_cnt_i (time_cnt_q),
        .window_i   (window_q),
        .peak_i     (peak_q),
        .state_o    (ch_state[gi]),
        .stamp_o    (ch_stamp[gi]),
        .valid_o    (ch_valid[gi])
      );
    end
  endgenerate

  assign irq = |ch_valid;

`ifdef RTC_BURST_OUT_EN
  logic [CNT_W-1:0] burst_len_q, burst_cnt_q, burst_ts_q;
  logic             burst_act_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      burst_len_q <= CNT_W'(BURST_LEN_DEF);
      burst_cnt_q <= '0;
      burst_ts_q  <= '0;
      burst_act_q <= 1'b0;
    end else begin
      if (avalon_slave_write && reg_sel == REG_BLEN) burst_len_q <= wdata_cnt;
      if (burst_act_q) begin
        burst_cnt_q <= burst_cnt_q - CNT_W'(1);
        if (burst_cnt_q == CNT_W'(1)) burst_act_q <= 1'b0;
      end else if (avalon_slave_write && reg_sel == REG_BURST && |avalon_slave_writedata) begin
        burst_ts_q <= time_cnt_q;
        if (burst_len_q != '0) begin
          burst_act_q <= 1'b1;
          burst_cnt_q <= burst_len_q;
        end
      end
    end
  end

  assign piezo_enable = burst_act_q;
`else
  assign piezo_enable = 1'b0;
`endif

  always_comb begin
    sel_state = ST_IDLE;
    sel_stamp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 8'(i)) begin
        sel_state = ch_state[i];
        sel_stamp = ch_stamp[i];
      end
    end
  end

  always_comb begin
    rd_mux = DEADBEEF;
    case (reg_sel)
      REG_TIME:   rd_mux = 32'(time_cnt_q);
      REG_STATE:  if (ch_ok) rd_mux = {30'b0, sel_state};
      REG_STAMP:  if (ch_ok) rd_mux = 32'(sel_stamp);
      REG_WINDOW: rd_mux = 32'(window_q);
      REG_PEAK:   rd_mux = 32'(peak_q);
`ifdef RTC_BURST_OUT_EN
      REG_BLEN:   rd_mux = 32'(burst_len_q);
      REG_BURST:  rd_mux = {31'b0, burst_act_q};
      REG_BTS:    rd_mux = 32'(burst_ts_q);
`endif
      default:    rd_mux = DEADBEEF;
    endcase
  end

  // One wait state per read; a held read strobe starts a fresh transfer after completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_done_q  <= 1'b0;
      readdata_q <= '0;
    end else if (avalon_slave_read && !rd_done_q) begin
      rd_done_q  <= 1'b1;
      readdata_q <= rd_mux;
    end else begin
      rd_done_q  <= 1'b0;
    end
  end

  assign avalon_slave_waitrequest = avalon_slave_read & ~rd_done_q;
  assign avalon_slave_readdata    = readdata_q;

endmodule

// File: tb/tb_rtc_multi_capture.sv
// Directed bench for rtc_multi_capture; burst checks follow RTC_BURST_OUT_EN.
module tb_rtc_multi_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  event_in = '0;
  logic [15:0] addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        wait_o, irq, piezo;

  int errors = 0;
  int checks = 0;

  always #10 clock = ~clock;

  rtc_multi_capture dut (
    .clock                    (clock),
    .reset                    (reset),
    .event_in                 (event_in),
    .avalon_slave_address     (addr),
    .avalon_slave_write       (wr),
    .avalon_slave_writedata   (wdata),
    .avalon_slave_read        (rd),
    .avalon_slave_readdata    (rdata),
    .avalon_slave_waitrequest (wait_o),
    .irq                      (irq),
    .piezo_enable             (piezo)
  );

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clock);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output int waits);
    @(negedge clock);
    addr = a; rd = 1'b1; waits = 0;
    #1;
    while (wait_o === 1'b1 && waits < 10) begin
      waits++;
      @(negedge clock);
      #1;
    end
    d = rdata;
    rd = 1'b0;
    $display("rd addr=%h data=%h waits=%0d", a, d, waits);
  endtask

  task automatic test_reset();
    logic [31:0] d; int w;
    reset = 1'b1; event_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0 || irq !== 1'b0 || piezo !== 1'b0 || wait_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got rd=%h irq=%b pz=%b wt=%b expected all 0", rdata, irq, piezo, wait_o);
    end
    bus_read(16'h0000, d, w);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL reset_time_cnt: got %h expected 1", d); end
    checks++; if (w !== 1) begin errors++; $display("FAIL read_wait: got %0d expected 1", w); end
    bus_read(16'h0400, d, w);
    checks++; if (d !== 32'd4000) begin errors++; $display("FAIL reset_window: got %0d expected 4000", d); end
    bus_read(16'h0500, d, w);
    checks++; if (d !== 32'd2500) begin errors++; $display("FAIL reset_peak: got %0d expected 2500", d); end
    bus_read(16'h0100, d, w);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_state: got %h expected 0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d; int w;
    bus_write(16'h0300, 32'd1);
    bus_read(16'h0100, d, w);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL glitch_armed: got %h expected 1", d); end
    @(negedge clock); event_in[0] = 1'b1;
    repeat (10) @(negedge clock);
    event_in[0] = 1'b0;
    repeat (100) @(negedge clock);
    bus_read(16'h0100, d, w);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL glitch_qualify: got %h expected 2", d); end
    repeat (4000) @(negedge clock);
    bus_read(16'h0100, d, w);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL glitch_rearmed: got %h expected 1", d); end
    bus_read(16'h0200, d, w);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL glitch_stamp: got %h expected 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_capture(input int ch, input logic [31:0] t0, input int delay, input logic [31:0] exp_stamp);
    logic [31:0] d; int w;
    bus_write(16'h0300 | 16'(ch), 32'd1);
    bus_write(16'h0000, t0);
    repeat (delay) @(negedge clock);
    event_in[ch] = 1'b1;
    repeat (3000) @(negedge clock);
    event_in[ch] = 1'b0;
    repeat (1100) @(negedge clock);
    bus_read(16'h0100 | 16'(ch), d, w);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL capture_state ch%0d: got %h expected 3", ch, d); end
    bus_read(16'h0200 | 16'(ch), d, w);
    checks++; if (d !== exp_stamp) begin errors++; $display("FAIL capture_stamp ch%0d: got %h expected %h", ch, d, exp_stamp); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL capture_irq ch%0d: got %b expected 1", ch, irq); end
  endtask

  task automatic test_rearm();
    logic [31:0] d; int w;
    bus_write(16'h0301, 32'd5);
    bus_read(16'h0101, d, w);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL rearm_state: got %h expected 1", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rearm_irq_other: got %b expected 1", irq); end
    bus_write(16'h0302, 32'd0);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL disarm_irq: got %b expected 0", irq); end
    bus_read(16'h0102, d, w);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL disarm_state: got %h expected 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; int w;
    bus_read(16'h0207, d, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL bad_ch_wait: got %0d expected 1", w); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL bad_ch_data: got %h expected deadbeef", d); end
    bus_read(16'h0900, d, w);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL bad_reg_data: got %h expected deadbeef", d); end
  endtask

  task automatic test_burst();
    logic [31:0] d; int w; int hi;
`ifdef RTC_BURST_OUT_EN
    bus_write(16'h0600, 32'd10);
    bus_read(16'h0600, d, w);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL burst_len: got %0d expected 10", d); end
    bus_write(16'h0000, 32'd100);
    addr = 16'h0700; wdata = 32'd1; wr = 1'b1;
    @(negedge clock);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 1) wr = 1'b0;
      #1 if (piezo === 1'b1) hi++;
      @(negedge clock);
    end
    $display("burst high_cycles=%0d", hi);
    checks++; if (hi !== 10) begin errors++; $display("FAIL burst_width: got %0d expected 10", hi); end
    bus_read(16'h0800, d, w);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL burst_ts: got %0d expected 100", d); end
    bus_read(16'h0700, d, w);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL burst_active: got %h expected 0", d); end
`else
    bus_write(16'h0700, 32'd1);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (piezo !== 1'b0) hi++;
      @(negedge clock);
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL piezo_off: got %0d high cycles expected 0", hi); end
    bus_read(16'h0600, d, w);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL burst_len_off: got %h expected deadbeef", d); end
    bus_read(16'h0800, d, w);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL burst_ts_off: got %h expected deadbeef", d); end
`endif
  endtask

  task automatic test_reset_mid_qualify();
    logic [31:0] d; int w;
    bus_write(16'h0303, 32'd1);
    event_in[3] = 1'b1;
    repeat (50) @(negedge clock);
    bus_read(16'h0103, d, w);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL midq_state: got %h expected 2", d); end
    @(negedge clock);
    reset = 1'b1; event_in = '0;
    #1;
    checks++; if (rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL midq_reset_out: got rd=%h irq=%b expected 0 0", rdata, irq);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bus_read(16'h0000, d, w);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL midq_time_cnt: got %h expected 1", d); end
    for (int c = 0; c < 4; c++) begin
      bus_read(16'h0100 | 16'(c), d, w);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL midq_idle ch%0d: got %h expected 0", c, d); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_capture(1, 32'h1000_0000, 0, 32'h1000_0003);
    test_capture(2, 32'hFFFF_FFFE, 5, 32'h0000_0006);
    test_rearm();
    test_unmapped();
    test_burst();
    test_reset_mid_qualify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
